// File: rtl/cache_fill_writer_pkg.sv
// Shared types and field widths for the cache fill writer.
package cache_fill_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } fill_state_e;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned WORD_W   = 3;
    localparam int unsigned DATA_W   = 16;

    // Tag bits left after removing the set index and block offset.
    function automatic int unsigned tag_width(input int unsigned sets);
        return ADDR_W - OFFSET_W - int'($clog2(sets));
    endfunction

endpackage

// File: rtl/cache_fill_writer_word_counter.sv
// Word counter for a block fill: load-zero, increment, terminal-count flag.
module fill_word_counter #(
    parameter int unsigned WORDS = 8,
    localparam int unsigned CNT_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_zero,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    // Counter register; wraps naturally when the last word is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load_zero) begin
            count <= '0;
        end else if (incr) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(WORDS - 1));

endmodule

// File: rtl/cache_fill_writer.sv
// Cache block fill writer: streams returning memory words into the data
// array, then writes {valid, tag} to the metadata array in one COMMIT cycle.
// Optional macro CACHE_FILL_BYPASS_EN adds a critical-word bypass port.
module cache_fill_writer
    import cache_fill_writer_pkg::*;
#(
    parameter int unsigned SETS  = 64,
    parameter int unsigned WORDS = 8,
    localparam int unsigned SET_W = $clog2(SETS),
    localparam int unsigned CNT_W = $clog2(WORDS),
    localparam int unsigned TAG_W = tag_width(SETS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fill_start,
    input  logic [ADDR_W-1:0]  fill_address,
    input  logic               victim_way,
    input  logic               mem_data_valid,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               busy,
    output logic               data_wen,
    output logic [SET_W-1:0]   data_set,
    output logic               data_way,
    output logic [WORDS-1:0]   data_word_en,
    output logic [DATA_W-1:0]  data_wdata,
    output logic               meta_wen,
    output logic [TAG_W:0]     meta_wdata,
    output logic               fill_done,
    output logic               fill_error
`ifdef CACHE_FILL_BYPASS_EN
    ,
    output logic               bypass_valid,
    output logic [DATA_W-1:0]  bypass_data
`endif
);

    fill_state_e        state_q;
    fill_state_e        state_d;
    logic [TAG_W-1:0]   tag_q;
    logic [SET_W-1:0]   set_q;
    logic               way_q;
    logic [WORD_W-1:0]  req_word_q;
    logic               error_q;
    logic               start_accept;
    logic               word_write;
    logic               commit;
    logic               stray_valid;
    logic [CNT_W-1:0]   word_count;
    logic               last_word;

    fill_word_counter #(.WORDS(WORDS)) u_word_counter (
        .clk       (clk),
        .rst       (rst),
        .load_zero (start_accept),
        .incr      (word_write),
        .count     (word_count),
        .terminal  (last_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes; reset suppresses every strobe so a
    // COMMIT cycle coinciding with reset never writes metadata.
    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        word_write   = 1'b0;
        commit       = 1'b0;
        stray_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stray_valid = mem_data_valid;
                if (fill_start) begin
                    start_accept = 1'b1;
                    state_d      = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_data_valid) begin
                    word_write = 1'b1;
                    if (last_word) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                stray_valid = mem_data_valid;
                commit      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            start_accept = 1'b0;
            word_write   = 1'b0;
            commit       = 1'b0;
            stray_valid  = 1'b0;
        end
    end

    // Capture the fill target when a fill is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= '0;
            set_q      <= '0;
            way_q      <= 1'b0;
            req_word_q <= '0;
        end else if (start_accept) begin
            tag_q      <= fill_address[ADDR_W-1 -: TAG_W];
            set_q      <= fill_address[OFFSET_W +: SET_W];
            way_q      <= victim_way;
            req_word_q <= fill_address[OFFSET_W-1 -: WORD_W];
        end
    end

    // Sticky protocol error: data returned while no fill is collecting words.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (stray_valid) begin
            error_q <= 1'b1;
        end
    end

    // Data-array write port, one word per accepted valid.
    always_comb begin
        data_word_en = '0;
        if (word_write) begin
            data_word_en[word_count] = 1'b1;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign data_wen   = word_write;
    assign data_wdata = word_write ? mem_data : '0;
    assign data_set   = set_q;
    assign data_way   = way_q;
    assign meta_wen   = commit;
    assign fill_done  = commit;
    assign meta_wdata = {1'b1, tag_q};
    assign fill_error = error_q;

`ifdef CACHE_FILL_BYPASS_EN
    logic bypass_hit;
    logic unused_bits;

    assign bypass_hit   = word_write && (word_count == CNT_W'(req_word_q));
    assign bypass_valid = bypass_hit;
    assign bypass_data  = bypass_hit ? mem_data : '0;
    assign unused_bits  = fill_address[0];
`else
    logic unused_bits;

    assign unused_bits = ^{fill_address[0], req_word_q};
`endif

endmodule

// File: tb/tb_cache_fill_writer.sv
// Self-checking bench for cache_fill_writer (SETS=64, WORDS=8).
module tb_cache_fill_writer;

    localparam int unsigned WORDS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_start;
    logic [15:0] fill_address;
    logic        victim_way;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        busy;
    logic        data_wen;
    logic [5:0]  data_set;
    logic        data_way;
    logic [7:0]  data_word_en;
    logic [15:0] data_wdata;
    logic        meta_wen;
    logic [6:0]  meta_wdata;
    logic        fill_done;
    logic        fill_error;
`ifdef CACHE_FILL_BYPASS_EN
    logic        bypass_valid;
    logic [15:0] bypass_data;
`endif

    cache_fill_writer dut (
        .clk            (clk),
        .rst            (rst),
        .fill_start     (fill_start),
        .fill_address   (fill_address),
        .victim_way     (victim_way),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .busy           (busy),
        .data_wen       (data_wen),
        .data_set       (data_set),
        .data_way       (data_way),
        .data_word_en   (data_word_en),
        .data_wdata     (data_wdata),
        .meta_wen       (meta_wen),
        .meta_wdata     (meta_wdata),
        .fill_done      (fill_done),
        .fill_error     (fill_error)
`ifdef CACHE_FILL_BYPASS_EN
        ,
        .bypass_valid   (bypass_valid),
        .bypass_data    (bypass_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model of the fill transaction: is a block being collected, how many
    // words have arrived, is the metadata write due, has an error been seen.
    bit          m_filling = 1'b0;
    bit          m_commit  = 1'b0;
    bit          m_err     = 1'b0;
    int          m_words   = 0;
    logic [15:0] m_addr    = '0;
    logic        m_way     = 1'b0;

    // Observation logs for hand-computed literal checks.
    logic [7:0]  log_en[$];
    logic [15:0] log_data[$];
    int          meta_count;
    int          done_count;
    int          busy_cycles;
    logic [6:0]  last_meta;
    logic [5:0]  last_set;
    int          byp_count;
    logic [15:0] last_byp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        log_en.delete();
        log_data.delete();
        meta_count  = 0;
        done_count  = 0;
        busy_cycles = 0;
        last_meta   = '0;
        last_set    = '0;
        byp_count   = 0;
        last_byp    = '0;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with
    // the inputs that the coming rising edge will sample.
    always @(negedge clk) begin : cmp
        bit e_busy;
        bit e_wen;
        bit e_meta;
        e_busy = m_filling || m_commit;
        e_wen  = !rst && m_filling && mem_data_valid;
        e_meta = !rst && m_commit;
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("data_wen", 32'(data_wen), 32'(e_wen));
            chk("meta_wen", 32'(meta_wen), 32'(e_meta));
            chk("fill_done", 32'(fill_done), 32'(e_meta));
            chk("fill_error", 32'(fill_error), 32'(m_err));
            if (e_busy) begin
                chk("data_set", 32'(data_set), 32'(m_addr[9:4]));
                chk("data_way", 32'(data_way), 32'(m_way));
            end
            if (e_wen) begin
                chk("data_word_en", 32'(data_word_en), 32'(1) << m_words);
                chk("data_wdata", 32'(data_wdata), 32'(mem_data));
            end
            if (e_meta) begin
                chk("meta_wdata", 32'(meta_wdata), 32'({1'b1, m_addr[15:10]}));
            end
`ifdef CACHE_FILL_BYPASS_EN
            chk("bypass_valid", 32'(bypass_valid),
                32'(e_wen && (m_words == int'(m_addr[3:1]))));
            if (bypass_valid) begin
                chk("bypass_data", 32'(bypass_data), 32'(mem_data));
                byp_count++;
                last_byp = bypass_data;
            end
`endif
            if (busy) busy_cycles++;
            if (data_wen) begin
                log_en.push_back(data_word_en);
                log_data.push_back(data_wdata);
                last_set = data_set;
            end
            if (meta_wen) begin
                meta_count++;
                last_meta = meta_wdata;
            end
            if (fill_done) done_count++;
        end
        if (rst) begin
            m_filling = 1'b0;
            m_commit  = 1'b0;
            m_err     = 1'b0;
            m_words   = 0;
            m_addr    = '0;
            m_way     = 1'b0;
        end else if (m_commit) begin
            m_commit = 1'b0;
            if (mem_data_valid) m_err = 1'b1;
        end else if (m_filling) begin
            if (mem_data_valid) begin
                m_words++;
                if (m_words == WORDS) begin
                    m_filling = 1'b0;
                    m_commit  = 1'b1;
                end
            end
        end else begin
            if (mem_data_valid) m_err = 1'b1;
            if (fill_start) begin
                m_filling = 1'b1;
                m_words   = 0;
                m_addr    = fill_address;
                m_way     = victim_way;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] addr, input logic way);
        fill_start   = 1'b1;
        fill_address = addr;
        victim_way   = way;
        cyc();
        fill_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        mem_data_valid = 1'b0;
        for (int g = 0; g < gap; g++) cyc();
        mem_data_valid = 1'b1;
        mem_data       = d;
        cyc();
        mem_data_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic check_block(input string tag, input logic [15:0] base);
        chk({tag, "_nwrites"}, 32'(log_en.size()), 32'(8));
        for (int i = 0; i < 8 && i < log_en.size(); i++) begin
            chk({tag, "_word_en"}, 32'(log_en[i]), 32'(1) << i);
            chk({tag, "_wdata"}, 32'(log_data[i]), 32'(base) + 32'(i));
        end
    endtask

    initial begin
        rst            = 1'b1;
        fill_start     = 1'b0;
        fill_address   = '0;
        victim_way     = 1'b0;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        clear_logs();
        cyc();
        cyc();
        rst    = 1'b0;
        cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_fill_error", 32'(fill_error), 32'(0));
        chk("rst_data_set", 32'(data_set), 32'(0));

        // Back-to-back fill at 0xABC6 way 1.
        clear_logs();
        start(16'hABC6, 1'b1);
        for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 0);
        cyc();
        cyc();
        check_block("b2b", 16'h1000);
        chk("b2b_set", 32'(last_set), 32'h3C);
        chk("b2b_meta", 32'(last_meta), 32'h6A);
        chk("b2b_meta_count", 32'(meta_count), 32'(1));
        chk("b2b_done_count", 32'(done_count), 32'(1));
        chk("b2b_busy_cycles", 32'(busy_cycles), 32'(9));

        // Same fill, each valid arriving on every third cycle.
        clear_logs();
        start(16'hABC6, 1'b1);
        for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 2);
        cyc();
        cyc();
        check_block("gap", 16'h1000);
        chk("gap_meta", 32'(last_meta), 32'h6A);
        chk("gap_busy_cycles", 32'(busy_cycles), 32'(25));

        // fill_start in the middle of a fill is ignored.
        clear_logs();
        start(16'hABC6, 1'b1);
        for (int i = 0; i < 3; i++) send(16'h3000 + 16'(i), 0);
        start(16'h0000, 1'b0);
        for (int i = 3; i < 8; i++) send(16'h3000 + 16'(i), 0);
        cyc();
        cyc();
        check_block("midstart", 16'h3000);
        chk("midstart_set", 32'(last_set), 32'h3C);
        chk("midstart_meta", 32'(last_meta), 32'h6A);

        // Reset after five words abandons the fill; a fresh fill completes.
        clear_logs();
        start(16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) send(16'h4000 + 16'(i), 0);
        pulse_reset();
        chk("abort_busy", 32'(busy), 32'(0));
        cyc();
        chk("abort_meta_count", 32'(meta_count), 32'(0));
        clear_logs();
        start(16'hABC6, 1'b1);
        for (int i = 0; i < 8; i++) send(16'h2000 + 16'(i), 0);
        cyc();
        cyc();
        check_block("refill", 16'h2000);
        chk("refill_meta_count", 32'(meta_count), 32'(1));

        // Reset coinciding with the COMMIT cycle suppresses the metadata write.
        clear_logs();
        start(16'hABC6, 1'b1);
        for (int i = 0; i < 8; i++) send(16'h5000 + 16'(i), 0);
        pulse_reset();
        cyc();
        chk("rstcommit_meta_count", 32'(meta_count), 32'(0));
        chk("rstcommit_done_count", 32'(done_count), 32'(0));

        // Stray valid in IDLE: no write, sticky error until reset.
        clear_logs();
        mem_data_valid = 1'b1;
        mem_data       = 16'hDEAD;
        cyc();
        mem_data_valid = 1'b0;
        cyc();
        cyc();
        chk("stray_nwrites", 32'(log_en.size()), 32'(0));
        chk("stray_error", 32'(fill_error), 32'(1));
        pulse_reset();
        chk("stray_error_cleared", 32'(fill_error), 32'(0));

        // fill_start with a simultaneous valid: fill starts, valid is an error.
        clear_logs();
        mem_data_valid = 1'b1;
        mem_data       = 16'hBEEF;
        start(16'hABC6, 1'b0);
        for (int i = 0; i < 8; i++) send(16'h6000 + 16'(i), 0);
        cyc();
        cyc();
        check_block("startvalid", 16'h6000);
        chk("startvalid_error", 32'(fill_error), 32'(1));
        pulse_reset();

        // Valid during COMMIT: metadata still written, error raised.
        clear_logs();
        start(16'hABC6, 1'b1);
        for (int i = 0; i < 8; i++) send(16'h7000 + 16'(i), 0);
        mem_data_valid = 1'b1;
        mem_data       = 16'h7777;
        cyc();
        mem_data_valid = 1'b0;
        cyc();
        check_block("commitvalid", 16'h7000);
        chk("commitvalid_meta_count", 32'(meta_count), 32'(1));
        chk("commitvalid_error", 32'(fill_error), 32'(1));
        pulse_reset();

`ifdef CACHE_FILL_BYPASS_EN
        // Critical word 3 of address 0x0016 is bypassed on the fourth valid.
        clear_logs();
        start(16'h0016, 1'b0);
        for (int i = 0; i < 8; i++) send(16'h8000 + 16'(i), 0);
        cyc();
        cyc();
        chk("bypass_count", 32'(byp_count), 32'(1));
        chk("bypass_word", 32'(last_byp), 32'h8003);
        chk("bypass_meta", 32'(last_meta), 32'h40);
`endif

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_writer.md
CACHE_FILL_WRITER -- requirements
Module: cache_fill_writer

Interface
REQ-001 SHALL have parameter SETS, default 64, number of cache sets; index width = log2(SETS).
REQ-002 SHALL have parameter WORDS, default 8, 16-bit words per block; word offset width = log2(WORDS).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port fill_start  in  1  one-cycle pulse that opens a fill.
REQ-006 SHALL have port fill_address  in  16  missing address, sampled on an accepted fill_start.
REQ-007 SHALL have port victim_way  in  1  way to fill, sampled on an accepted fill_start.
REQ-008 SHALL have port mem_data_valid  in  1  returning memory word valid.
REQ-009 SHALL have port mem_data  in  16  returning memory word.
REQ-010 SHALL have port busy  out  1  high in FILL and COMMIT (pipeline stall).
REQ-011 SHALL have port data_wen  out  1  data-array write strobe.
REQ-012 SHALL have port data_set  out  log2(SETS)  data-array set index.
REQ-013 SHALL have port data_way  out  1  data-array way.
REQ-014 SHALL have port data_word_en  out  WORDS  one-hot word enable.
REQ-015 SHALL have port data_wdata  out  16  data-array write data.
REQ-016 SHALL have port meta_wen  out  1  metadata write strobe.
REQ-017 SHALL have port meta_wdata  out  16-log2(SETS)-4+1  {valid=1, tag}.
REQ-018 SHALL have port fill_done  out  1  one-cycle completion pulse.
REQ-019 SHALL have port fill_error  out  1  sticky protocol-error flag.

Function
REQ-020 Address split SHALL be tag = fill_address[15:4+log2(SETS)], set = fill_address[3+log2(SETS):4], word = fill_address[3:1].
REQ-021 FSM SHALL have three states: IDLE, FILL, COMMIT.
REQ-022 IDLE + fill_start SHALL latch tag, set, way and requested word, clear the word counter to 0, and enter FILL next cycle.
REQ-023 In FILL, each mem_data_valid SHALL drive data_wen=1, data_word_en=one-hot(counter), data_wdata=mem_data combinationally in the same cycle, then increment the counter.
REQ-024 Words SHALL be taken in order 0..WORDS-1; the counter SHALL be log2(WORDS) bits and wrap only on FILL exit.
REQ-025 The valid that carries word WORDS-1 SHALL move FILL to COMMIT.
REQ-026 COMMIT SHALL last exactly one cycle with meta_wen=1, fill_done=1 and meta_wdata={1'b1, latched tag}, then return to IDLE.
REQ-027 fill_start in FILL or COMMIT SHALL be ignored with no state change.
REQ-028 mem_data_valid in IDLE or COMMIT SHALL cause no write and SHALL set fill_error.
REQ-029 fill_start and mem_data_valid together in IDLE SHALL start the fill only; the valid SHALL be counted as an error.
REQ-030 data_set and data_way SHALL show the latched values whenever busy=1.
REQ-031 Gaps of any length between valids SHALL be tolerated; busy SHALL stay high.

Reset
REQ-032 rst SHALL force IDLE, counter 0, busy=0, data_wen=0, meta_wen=0, fill_done=0, fill_error=0, latched fields 0.
REQ-033 rst during FILL or COMMIT SHALL abandon the fill with no meta_wen, including a COMMIT cycle coinciding with rst.

Configuration
REQ-034 Macro CACHE_FILL_BYPASS_EN, when defined, SHALL add outputs bypass_valid (1) and bypass_data (16), driven high with mem_data for one cycle when the word at the latched requested offset is written.
REQ-035 Without CACHE_FILL_BYPASS_EN those ports SHALL be absent and behaviour otherwise identical.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the field-width constants (offset 4, word 3, data 16) and the tag-width function.
REQ-037 The word counter SHALL be a sub-module fill_word_counter (load-zero, increment, terminal-count output).

Verification
REQ-038 Start at 0xABC6 way 1, 8 valids back-to-back of 0x1000..0x1007 -> word_en 0x01..0x80, set 0x3C, COMMIT next cycle with meta_wdata {1,tag 0x2A}, fill_done once.
REQ-039 Same fill with 3-cycle gaps between valids -> identical writes, busy held high for 25 cycles.
REQ-040 fill_start mid-FILL with address 0x0000 -> ignored, set and tag unchanged.
REQ-041 mem_data_valid in IDLE -> no data_wen, fill_error=1 until rst.
REQ-042 rst after 5 words -> IDLE next cycle, no meta_wen; a fresh fill then completes normally.
REQ-043 With CACHE_FILL_BYPASS_EN, address 0x0016 -> bypass_valid only on 4th valid, bypass_data equal to that word.
